clk_div_monitor: RTL and testbench
==================================

// Module: clk_div_monitor
// PURPOSE
//  Receiving end of the clock-divider interface: samples a divided clock
//  (e.g. the 50%-duty divide-by-5 output) in the clk_in domain.
//  Measures period and high time in clk_in cycles and checks both against DIV.
//  Reports lock, errors and per-period measurements to the on-board self-check
//  logic, and doubles as a synthesizable checker in divider benches.
// PARAMETERS
//  DIV       5   expected division ratio (>=2)
//  CNT_W     8   width of period/high counters; must hold 2*DIV
//  LOCK_CNT  4   consecutive good periods required to assert locked
// PORTS
//  clk_in     in   1      reference clock; all logic on posedge
//  rst        in   1      reset, asynchronous, active-low
//  en         in   1      1 = monitor runs; 0 = return to IDLE (outputs hold)
//  clear      in   1      sync pulse: clears err and err_code
//  clk_div    in   1      divided clock under test
//  period     out  CNT_W  last measured period, clk_in cycles
//  high_cnt   out  CNT_W  posedge samples with clk_div=1 in last period
//  meas_valid out  1      1-cycle pulse: period/high_cnt just updated
//  locked     out  1      LOCK_CNT consecutive good periods seen
//  err        out  1      sticky error flag
//  err_code   out  2      first error: 00 none,01 period,10 duty,11 stall
// BEHAVIOUR
//  Reset (rst=0, async): all outputs 0, all counters 0, state IDLE.
//  Sampling: d1<=clk_div, d2<=d1 on every posedge; rise = d1 & ~d2.
//   Edge-detect latency: 2 clk_in cycles after clk_div goes high.
//  cnt: loads 1 on a rise; otherwise +1 per cycle, saturating at 2^CNT_W-1.
//  hcnt: loads d1 on a rise; otherwise +d1 per cycle, saturating.
//  FSM:
//   IDLE -> MEAS on the first rise while en=1. That rise starts the count only:
//    no meas_valid is produced for it.
//   MEAS: on each rise, register period<=cnt and high_cnt<=hcnt, and pulse
//    meas_valid in the next cycle.
//    A period is good when period==DIV and high_cnt is in
//     {DIV/2, (DIV+1)/2} (integer division).
//    A good period increments good_cnt; at LOCK_CNT, go to LOCKED and set
//     locked=1.
//    A bad period clears good_cnt and raises an error.
//   LOCKED: same measurement. A bad period -> MEAS, locked=0, error raised.
//   Stall: in MEAS/LOCKED, cnt reaching 2*DIV with no rise -> code 11, IDLE,
//    locked=0, counters cleared.
//  Error priority within one event: stall > period (01) > duty (10).
//  err_code latches only when err=0, so the first error is kept until clear.
//  clear and a new error in the same cycle: the new error wins (err stays 1).
//  en=0: go to IDLE, clear cnt/hcnt/good_cnt and locked.
//   period, high_cnt, err and err_code hold their values.
//  rst low mid-measurement: immediate return to the reset state.
//   No meas_valid is issued for the partial period.
//  clk_div stuck high: no rise occurs, so this is reported as a stall after
//   2*DIV cycles.
// TESTING
//  1 Drive clk_div from a 50%-duty divide-by-5 model, en=1, DIV=5
//    -> period=5 and high_cnt in {2,3} on every meas_valid;
//       locked=1 after the 4th good period; err=0.
//  2 Hold clk_div=0 after lock -> 10 cycles after the last rise:
//    err=1, err_code=11, locked=0, FSM in IDLE.
//  3 Feed a divide-by-6 clock -> first meas_valid shows period=6;
//    err=1, err_code=01; locked never set.
//  4 Period-5 clock with 1-cycle high pulses -> high_cnt=1, err_code=10;
//    then pulse clear -> err=0, and a correct clock re-locks
//    after 4 good periods.
//  5 Assert rst low 3 cycles into a period while locked
//    -> all outputs 0 asynchronously; after release, the first rise gives
//       no meas_valid and the second rise gives period=5.
//  6 CNT_W=3, DIV=3, clock stopped -> cnt saturates/stalls at 6:
//    err_code=11, no counter wrap-around.

Source files
------------

// File: rtl/clk_div_monitor.sv
// ============================================================================
//  Module      : clk_div_monitor
//  Description : Samples a divided clock in the clk_in domain and measures its
//                period and high time. It checks both against DIV and reports
//                lock, a sticky first-error code and per-period results.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module clk_div_monitor #(
    parameter int DIV      = 5,
    parameter int CNT_W    = 8,
    parameter int LOCK_CNT = 4
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             en,
    input  logic             clear,
    input  logic             clk_div,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_cnt,
    output logic             meas_valid,
    output logic             locked,
    output logic             err,
    output logic [1:0]       err_code
);

    localparam int               c_GOOD_W   = $clog2(LOCK_CNT + 1);
    localparam logic [CNT_W-1:0] c_DIV      = CNT_W'(DIV);
    localparam logic [CNT_W-1:0] c_STALL    = CNT_W'(2 * DIV);
    localparam logic [CNT_W-1:0] c_HIGH_LO  = CNT_W'(DIV / 2);
    localparam logic [CNT_W-1:0] c_HIGH_HI  = CNT_W'((DIV + 1) / 2);
    localparam logic [CNT_W-1:0] c_CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [c_GOOD_W-1:0] c_LOCK    = c_GOOD_W'(LOCK_CNT);
    localparam logic [c_GOOD_W-1:0] c_LOCK_M1 = c_GOOD_W'(LOCK_CNT - 1);

    localparam logic [1:0] c_ERR_NONE   = 2'b00;
    localparam logic [1:0] c_ERR_PERIOD = 2'b01;
    localparam logic [1:0] c_ERR_DUTY   = 2'b10;
    localparam logic [1:0] c_ERR_STALL  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_MEAS   = 2'd1,
        S_LOCKED = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic                r_d1;
    logic                r_d2;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    r_hcnt;
    logic [c_GOOD_W-1:0] r_good_cnt;
    logic [c_GOOD_W-1:0] w_good_next;
    logic [CNT_W-1:0]    r_period;
    logic [CNT_W-1:0]    r_high_cnt;
    logic                r_meas_valid;
    logic                r_locked;
    logic                w_locked_next;
    logic                r_err;
    logic [1:0]          r_err_code;

    logic                w_rise;
    logic                w_meas;
    logic                w_cnt_clr;
    logic                w_period_ok;
    logic                w_duty_ok;
    logic                w_err_new;
    logic [1:0]          w_err_code_new;

    assign w_rise      = r_d1 & ~r_d2;
    assign w_period_ok = (r_cnt == c_DIV);
    assign w_duty_ok   = (r_hcnt == c_HIGH_LO) || (r_hcnt == c_HIGH_HI);

    // Two-flop sampler; the second stage also provides the rising-edge history
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            r_d1 <= 1'b0;
            r_d2 <= 1'b0;
        end else begin
            r_d1 <= clk_div;
            r_d2 <= r_d1;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_good_next    = r_good_cnt;
        w_locked_next  = r_locked;
        w_meas         = 1'b0;
        w_cnt_clr      = 1'b0;
        w_err_new      = 1'b0;
        w_err_code_new = c_ERR_NONE;

        if (!en) begin
            w_state_next  = S_IDLE;
            w_good_next   = '0;
            w_locked_next = 1'b0;
            w_cnt_clr     = 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_good_next   = '0;
                    w_locked_next = 1'b0;
                    if (w_rise) begin
                        w_state_next = S_MEAS;
                    end
                end
                S_MEAS, S_LOCKED: begin
                    if (w_rise) begin
                        w_meas = 1'b1;
                        if (w_period_ok && w_duty_ok) begin
                            if (r_state == S_MEAS) begin
                                if (r_good_cnt >= c_LOCK_M1) begin
                                    w_good_next   = c_LOCK;
                                    w_locked_next = 1'b1;
                                    w_state_next  = S_LOCKED;
                                end else begin
                                    w_good_next = r_good_cnt + 1'b1;
                                end
                            end
                        end else begin
                            w_err_new      = 1'b1;
                            w_err_code_new = w_period_ok ? c_ERR_DUTY : c_ERR_PERIOD;
                            w_good_next    = '0;
                            w_locked_next  = 1'b0;
                            w_state_next   = S_MEAS;
                        end
                    end else if (r_cnt >= c_STALL) begin
                        // No edge within two nominal periods: stopped or stuck clock
                        w_err_new      = 1'b1;
                        w_err_code_new = c_ERR_STALL;
                        w_good_next    = '0;
                        w_locked_next  = 1'b0;
                        w_cnt_clr      = 1'b1;
                        w_state_next   = S_IDLE;
                    end
                end
                default: begin
                    w_state_next  = S_IDLE;
                    w_good_next   = '0;
                    w_locked_next = 1'b0;
                    w_cnt_clr     = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            r_cnt  <= '0;
            r_hcnt <= '0;
        end else if (w_cnt_clr) begin
            r_cnt  <= '0;
            r_hcnt <= '0;
        end else if (w_rise) begin
            r_cnt  <= CNT_W'(1);
            r_hcnt <= CNT_W'(r_d1);
        end else begin
            if (r_cnt != c_CNT_MAX) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (r_d1 && (r_hcnt != c_CNT_MAX)) begin
                r_hcnt <= r_hcnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_good_cnt   <= '0;
            r_locked     <= 1'b0;
            r_meas_valid <= 1'b0;
            r_period     <= '0;
            r_high_cnt   <= '0;
        end else begin
            r_state      <= w_state_next;
            r_good_cnt   <= w_good_next;
            r_locked     <= w_locked_next;
            r_meas_valid <= w_meas;
            if (w_meas) begin
                r_period   <= r_cnt;
                r_high_cnt <= r_hcnt;
            end
        end
    end

    // A clear coinciding with a new error lets the new error through as the first one
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            r_err      <= 1'b0;
            r_err_code <= c_ERR_NONE;
        end else begin
            if (w_err_new) begin
                r_err <= 1'b1;
            end else if (clear) begin
                r_err <= 1'b0;
            end
            if (w_err_new && (!r_err || clear)) begin
                r_err_code <= w_err_code_new;
            end else if (clear) begin
                r_err_code <= c_ERR_NONE;
            end
        end
    end

    assign period     = r_period;
    assign high_cnt   = r_high_cnt;
    assign meas_valid = r_meas_valid;
    assign locked     = r_locked;
    assign err        = r_err;
    assign err_code   = r_err_code;

endmodule

`default_nettype wire

// File: tb/tb_clk_div_monitor.sv
// ============================================================================
//  Module      : tb_clk_div_monitor
//  Description : Directed bench for clk_div_monitor with a measurement
//                scoreboard plus status checks on a DIV=5 and a DIV=3 instance.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_clk_div_monitor;

    logic       clk = 1'b0;
    logic       rst;
    logic       en, clear, clk_div;
    logic [7:0] period, high_cnt;
    logic       meas_valid, locked, err;
    logic [1:0] err_code;

    logic       en3, clear3, clk_div3;
    logic [2:0] period3, high_cnt3;
    logic       meas_valid3, locked3, err3;
    logic [1:0] err_code3;

    always #5 clk = ~clk;

    clk_div_monitor #(.DIV(5), .CNT_W(8), .LOCK_CNT(4)) dut (
        .clk_in(clk), .rst(rst), .en(en), .clear(clear), .clk_div(clk_div),
        .period(period), .high_cnt(high_cnt), .meas_valid(meas_valid),
        .locked(locked), .err(err), .err_code(err_code)
    );

    clk_div_monitor #(.DIV(3), .CNT_W(3), .LOCK_CNT(4)) dut3 (
        .clk_in(clk), .rst(rst), .en(en3), .clear(clear3), .clk_div(clk_div3),
        .period(period3), .high_cnt(high_cnt3), .meas_valid(meas_valid3),
        .locked(locked3), .err(err3), .err_code(err_code3)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int p;
        int h;
    } exp_t;

    exp_t exp_q[$];
    int   prev_len;
    int   prev_high;
    bit   have_prev;
    bit   seen;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push_exp(input int p, input int h);
        exp_t e;
        e.p = p;
        e.h = h;
        exp_q.push_back(e);
    endtask

    // One clk_div period on the DIV=5 instance; its rise closes the previous period
    task automatic pulse(input int len, input int high, input int clr_at = -1);
        if (have_prev) push_exp(prev_len, prev_high);
        for (int i = 0; i < len; i++) begin
            clk_div = (i < high);
            clear   = (i == clr_at);
            @(negedge clk);
        end
        clk_div   = 1'b0;
        clear     = 1'b0;
        prev_len  = len;
        prev_high = high;
        have_prev = 1'b1;
    endtask

    task automatic pulse3(input int len, input int high);
        for (int i = 0; i < len; i++) begin
            clk_div3 = (i < high);
            @(negedge clk);
        end
        clk_div3 = 1'b0;
    endtask

    task automatic wait_err(input bit on3, input int max, output bit found);
        found = 1'b0;
        for (int i = 0; i < max && !found; i++) begin
            @(negedge clk);
            if (on3 ? err3 : err) found = 1'b1;
        end
    endtask

    // Scoreboard monitor: every measurement pulse must match the oldest expectation
    always @(negedge clk) begin
        if (rst && meas_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_meas: got period=%0d high_cnt=%0d expected no measurement",
                         period, high_cnt);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("meas_period", period, e.p);
                check("meas_high_cnt", high_cnt, e.h);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b0; en = 1'b0; clear = 1'b0; clk_div = 1'b0;
        en3 = 1'b0; clear3 = 1'b0; clk_div3 = 1'b0;
        have_prev = 1'b0; prev_len = 0; prev_high = 0;
        repeat (3) @(negedge clk);
        check("rst_period", period, 0);
        check("rst_high_cnt", high_cnt, 0);
        check("rst_meas_valid", meas_valid, 0);
        check("rst_locked", locked, 0);
        check("rst_err", err, 0);
        check("rst_err_code", err_code, 0);
        rst = 1'b1;
        @(negedge clk);

        // Nominal divide-by-5 clock: lock on the 4th good measurement
        en = 1'b1;
        pulse(5, 2); pulse(5, 3); pulse(5, 2); pulse(5, 3);
        check("lock_not_early", locked, 0);
        pulse(5, 2);
        check("locked_after_4", locked, 1);
        check("no_err_nominal", err, 0);

        // Stopped clock after lock
        repeat (5) @(negedge clk);
        check("no_early_stall", err, 0);
        wait_err(1'b0, 10, seen);
        check("stall_seen", seen, 1);
        check("stall_code", err_code, 3);
        check("stall_unlock", locked, 0);
        have_prev = 1'b0;

        // Divide-by-6 clock: period error, never locks
        clear = 1'b1; @(negedge clk); clear = 1'b0;
        check("clear_err", err, 0);
        check("clear_code", err_code, 0);
        pulse(6, 3); pulse(6, 3); pulse(6, 3); pulse(6, 3);
        check("div6_err", err, 1);
        check("div6_code", err_code, 1);
        check("div6_no_lock", locked, 0);
        en = 1'b0;
        repeat (2) @(negedge clk);
        check("en0_hold_period", period, 6);
        check("en0_hold_high", high_cnt, 3);
        check("en0_hold_code", err_code, 1);
        clear = 1'b1; @(negedge clk); clear = 1'b0;
        en = 1'b1;
        have_prev = 1'b0;

        // Narrow high pulses: duty error, then clear and re-lock
        pulse(5, 1); pulse(5, 1); pulse(5, 1);
        check("duty_err", err, 1);
        check("duty_code", err_code, 2);
        pulse(5, 2, 3);
        check("duty_cleared_err", err, 0);
        check("duty_cleared_code", err_code, 0);
        pulse(5, 3); pulse(5, 2); pulse(5, 3);
        check("relock_not_early", locked, 0);
        pulse(5, 2);
        check("relocked", locked, 1);
        check("relock_no_err", err, 0);

        // Asynchronous reset three cycles into a locked period
        push_exp(prev_len, prev_high);
        clk_div = 1'b1;
        @(negedge clk); @(negedge clk);
        clk_div = 1'b0;
        @(negedge clk);
        check("pre_rst_locked", locked, 1);
        #2 rst = 1'b0;
        #1;
        check("arst_period", period, 0);
        check("arst_high_cnt", high_cnt, 0);
        check("arst_locked", locked, 0);
        check("arst_meas_valid", meas_valid, 0);
        @(negedge clk); @(negedge clk);
        rst = 1'b1;
        have_prev = 1'b0;
        pulse(5, 2); pulse(5, 3);
        repeat (4) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);

        // DIV=3, CNT_W=3: stall at 6 with a stopped clock and a stuck-high clock
        en3 = 1'b1;
        pulse3(3, 1); pulse3(3, 1); pulse3(3, 1);
        check("d3_period", period3, 3);
        check("d3_high", high_cnt3, 1);
        check("d3_no_err", err3, 0);
        wait_err(1'b1, 12, seen);
        check("d3_stall_seen", seen, 1);
        check("d3_stall_code", err_code3, 3);
        check("d3_unlocked", locked3, 0);
        clear3 = 1'b1; @(negedge clk); clear3 = 1'b0;
        check("d3_clear", err3, 0);
        pulse3(3, 2); pulse3(3, 2);
        clk_div3 = 1'b1;
        repeat (3) @(negedge clk);
        check("d3_high2", high_cnt3, 2);
        check("d3_high2_no_err", err3, 0);
        wait_err(1'b1, 12, seen);
        check("d3_stuck_seen", seen, 1);
        check("d3_stuck_code", err_code3, 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
